decoder_n_reg: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder for register-file write enables in the 5-stage pipeline. It adds three things to a plain gated decoder: a pipeline register with stall/flush control, suppression of a hard-wired zero register, and a sweep mode that walks a single one-hot bit across every output, which is used to clear the register file after reset. With SEL_W=1 and ZERO_EN=0, normal mode is a registered 1:2 decoder with enable.

---
 rtl/decoder_n_reg_if.sv | 25 ++
 rtl/decoder_n_reg.sv | 95 +++++++++
 tb/tb_decoder_n_reg.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/decoder_n_reg_if.sv
// Bus bundle for decoder_n_reg: decode/sweep controls in, registered enables and status out.
// The master drives requests; the slave (the decoder) returns the registered results.
interface decoder_n_reg_if #(
  parameter int SEL_W = 5,
  parameter int NOUT  = 2 ** SEL_W
);
  logic [SEL_W-1:0] in;
  logic             en;
  logic             stall;
  logic             flush;
  logic             sweep_start;
  logic [NOUT-1:0]  out;
  logic             busy;
  logic             sweep_done;

  modport master (
    output in, en, stall, flush, sweep_start,
    input  out, busy, sweep_done
  );

  modport slave (
    input  in, en, stall, flush, sweep_start,
    output out, busy, sweep_done
  );
endinterface

// File: rtl/decoder_n_reg.sv
// Registered N-to-2^N one-hot decoder for register-file write enables, with stall/flush,
// hard-wired zero-register suppression and a sweep mode that walks one bit over every output.
module decoder_n_reg #(
  parameter int SEL_W    = 5,
  parameter int NOUT     = 2 ** SEL_W,
  parameter int ZERO_IDX = 31,
  parameter int ZERO_EN  = 1
) (
  input  logic           clk,
  input  logic           reset,
  decoder_n_reg_if.slave bus
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q,   cnt_d;
  logic [NOUT-1:0]  out_q,   out_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // The zero register never gets a write enable, whichever mode asks for it.
  function automatic logic [NOUT-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = '0;
    if (!((ZERO_EN != 0) && (int'(idx) == ZERO_IDX))) onehot[idx] = 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.flush) begin
          out_d = '0;
        end else if (bus.stall) begin
          // hold; a sweep request under stall is dropped, not queued
        end else if (bus.sweep_start) begin
          state_d = SWEEP;
          cnt_d   = '0;
          out_d   = onehot('0);
        end else begin
          out_d = bus.en ? onehot(bus.in) : '0;
        end
      end
      SWEEP: begin
        if (bus.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
          out_d   = '0;
        end else if (bus.stall) begin
          // hold the current index for another cycle
        end else if (cnt_q == SEL_W'(NOUT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          out_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + SEL_W'(1);
          out_d = onehot(cnt_q + SEL_W'(1));
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        out_d   = '0;
      end
    endcase
    busy_d = (state_d == SWEEP);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = done_q;

endmodule

// File: tb/tb_decoder_n_reg.sv
// Scoreboard bench for decoder_n_reg: two instances (zero register suppressed / not),
// directed scenarios followed by random traffic, checked against a behavioural model.
module tb_decoder_n_reg;

  localparam int SEL_W = 5;
  localparam int NOUT  = 32;

  typedef struct {
    logic [31:0] out;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  // model state per instance: 0 = zero register suppressed, 1 = all indices decode
  logic [31:0] m_out[2];
  logic        m_busy[2];
  logic        m_done[2];
  int          m_pos[2];

  decoder_n_reg_if #(.SEL_W(SEL_W), .NOUT(NOUT)) bus0 ();
  decoder_n_reg_if #(.SEL_W(SEL_W), .NOUT(NOUT)) bus1 ();

  decoder_n_reg #(.SEL_W(SEL_W), .ZERO_EN(1)) u_dut0 (.clk(clk), .reset(rst_n), .bus(bus0.slave));
  decoder_n_reg #(.SEL_W(SEL_W), .ZERO_EN(0)) u_dut1 (.clk(clk), .reset(rst_n), .bus(bus1.slave));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required end earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask(input int idx, input bit zero_en);
    logic [63:0] one;
    one = 64'd1 << idx;
    return (zero_en && idx == 31) ? 32'd0 : one[31:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = '0; m_busy[k] = 1'b0; m_done[k] = 1'b0; m_pos[k] = 0;
    end
  endtask

  // A sweep emits onehot(0..NOUT-1) on its unstalled cycles, then one done cycle.
  task automatic model_step(input int k, input bit fl, input bit st, input bit ss,
                            input bit e, input int idx);
    bit zen;
    zen = (k == 0);
    m_done[k] = 1'b0;
    if (m_busy[k]) begin
      if (fl) begin
        m_busy[k] = 1'b0; m_out[k] = '0;
      end else if (!st) begin
        m_pos[k]++;
        if (m_pos[k] == NOUT) begin
          m_busy[k] = 1'b0; m_out[k] = '0; m_done[k] = 1'b1;
        end else begin
          m_out[k] = mask(m_pos[k], zen);
        end
      end
    end else begin
      if (fl) m_out[k] = '0;
      else if (st) begin end
      else if (ss) begin
        m_busy[k] = 1'b1; m_pos[k] = 0; m_out[k] = mask(0, zen);
      end else m_out[k] = e ? mask(idx, zen) : 32'd0;
    end
  endtask

  task automatic step(input bit fl, input bit st, input bit ss, input bit e, input int idx);
    exp_t x;
    @(negedge clk);
    bus0.flush = fl; bus0.stall = st; bus0.sweep_start = ss; bus0.en = e; bus0.in = idx[4:0];
    bus1.flush = fl; bus1.stall = st; bus1.sweep_start = ss; bus1.en = e; bus1.in = idx[4:0];
    for (int k = 0; k < 2; k++) model_step(k, fl, st, ss, e, idx);
    x.out = m_out[0]; x.busy = m_busy[0]; x.done = m_done[0]; sb0.push_back(x);
    x.out = m_out[1]; x.busy = m_busy[1]; x.done = m_done[1]; sb1.push_back(x);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out0"},  64'(bus0.out), 64'd0);
    check({tag, " busy0"}, 64'(bus0.busy), 64'd0);
    check({tag, " done0"}, 64'(bus0.sweep_done), 64'd0);
    check({tag, " out1"},  64'(bus1.out), 64'd0);
    check({tag, " busy1"}, 64'(bus1.busy), 64'd0);
    check({tag, " done1"}, 64'(bus1.sweep_done), 64'd0);
  endtask

  // Reset is asserted between edges; outputs must clear without a clock edge.
  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    sb0.delete(); sb1.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor: one registered result per clock, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb0.size() > 0) begin
        e = sb0.pop_front();
        check("out0",  64'(bus0.out), 64'(e.out));
        check("busy0", 64'(bus0.busy), 64'(e.busy));
        check("done0", 64'(bus0.sweep_done), 64'(e.done));
      end
      if (rst_n && sb1.size() > 0) begin
        e = sb1.pop_front();
        check("out1",  64'(bus1.out), 64'(e.out));
        check("busy1", 64'(bus1.busy), 64'(e.busy));
        check("done1", 64'(bus1.sweep_done), 64'(e.done));
      end
    end
  end

  initial begin
    bus0.flush = 0; bus0.stall = 0; bus0.sweep_start = 0; bus0.en = 0; bus0.in = '0;
    bus1.flush = 0; bus1.stall = 0; bus1.sweep_start = 0; bus1.en = 0; bus1.in = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // plain decode and enable low
    step(0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 3);
    // zero register: suppressed on instance 0 only
    step(0, 0, 0, 1, 31);
    step(0, 0, 0, 1, 0);
    // stall holds 1<<7 despite in=9, then flush beats stall
    step(0, 0, 0, 1, 7);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 9);
    step(1, 1, 0, 1, 9);
    // stall on an idle cycle swallows a sweep request
    step(0, 1, 1, 0, 0);
    idle_steps(1);

    // full sweep, then a new sweep accepted on the done cycle
    step(0, 0, 1, 1, 4);
    for (int i = 0; i < 32; i++) step(0, 0, 0, 1, 4);
    step(0, 0, 1, 0, 0);
    idle_steps(33);

    // sweep stalled two cycles at index 5
    step(0, 0, 1, 0, 0);
    idle_steps(5);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 2);
    idle_steps(28);

    // sweep flushed at index 10: aborts without done
    step(0, 0, 1, 0, 0);
    idle_steps(10);
    step(1, 0, 0, 0, 0);
    idle_steps(2);

    // async reset mid-sweep at index 12, then normal decode resumes
    step(0, 0, 1, 0, 0);
    idle_steps(12);
    mid_reset();
    step(0, 0, 0, 1, 2);
    idle_steps(1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 6, 1'($urandom), int'($urandom_range(0, 31)));
    end
    idle_steps(40);

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
